// File: rtl/decode_queue_pkg.sv
// Shared constants and types for the decode queue: MIPS opcode/funct/selector
// encodings, ALU operation codes, the control-word layout and exception-tag indices.
package decode_queue_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_SLLV    = 6'h04;
    localparam logic [5:0] F_SRLV    = 6'h06;
    localparam logic [5:0] F_SRAV    = 6'h07;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_JALR    = 6'h09;
    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_BREAK   = 6'h0D;
    localparam logic [5:0] F_MFHI    = 6'h10;
    localparam logic [5:0] F_MTHI    = 6'h11;
    localparam logic [5:0] F_MFLO    = 6'h12;
    localparam logic [5:0] F_MTLO    = 6'h13;
    localparam logic [5:0] F_MULT    = 6'h18;
    localparam logic [5:0] F_MULTU   = 6'h19;
    localparam logic [5:0] F_DIV     = 6'h1A;
    localparam logic [5:0] F_DIVU    = 6'h1B;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2A;
    localparam logic [5:0] F_SLTU    = 6'h2B;
    localparam logic [5:0] F_ERET    = 6'h18;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;
    localparam logic [4:0] RS_MFC0   = 5'h00;
    localparam logic [4:0] RS_MTC0   = 5'h04;
    localparam logic [4:0] RS_CO     = 5'h10;

    localparam logic [3:0] USELESS_OP = 4'd0;
    localparam logic [3:0] MEM_OP     = 4'd1;
    localparam logic [3:0] R_TYPE_OP  = 4'd2;
    localparam logic [3:0] ANDI_OP    = 4'd3;
    localparam logic [3:0] ORI_OP     = 4'd4;
    localparam logic [3:0] XORI_OP    = 4'd5;
    localparam logic [3:0] LUI_OP     = 4'd6;
    localparam logic [3:0] ADDI_OP    = 4'd7;
    localparam logic [3:0] ADDIU_OP   = 4'd8;
    localparam logic [3:0] SLTI_OP    = 4'd9;
    localparam logic [3:0] SLTIU_OP   = 4'd10;
    localparam logic [3:0] MTC0_OP    = 4'd11;
    localparam logic [3:0] MFC0_OP    = 4'd12;

    localparam int unsigned EXC_INVALID = 3;
    localparam int unsigned EXC_SYSCALL = 2;
    localparam int unsigned EXC_BRK     = 1;
    localparam int unsigned EXC_ERET    = 0;

    // Field order is the 17-bit out_ctrl layout, MSB first.
    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memtoreg;
        logic       jump;
        logic       jal;
        logic       jr;
        logic       bal;
        logic       jalr;
        logic [3:0] aluop;
        logic       memen;
        logic [1:0] hilo_we;
    } ctrl_t;

    function automatic logic [3:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ADDI:  return ADDI_OP;
            OP_ADDIU: return ADDIU_OP;
            OP_SLTI:  return SLTI_OP;
            OP_SLTIU: return SLTIU_OP;
            OP_ANDI:  return ANDI_OP;
            OP_ORI:   return ORI_OP;
            OP_XORI:  return XORI_OP;
            OP_LUI:   return LUI_OP;
            default:  return USELESS_OP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS instruction decoder: control word, CP0 strobes and exception tags.
// Unrecognised encodings yield an all-zero control word with only the invalid tag set.
module ctrl_decode
    import decode_queue_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_cp0_we,
    output logic        o_cp0_re,
    output logic [3:0]  o_exc
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_invalid;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_rs     = i_instr[25:21];
    assign w_rt     = i_instr[20:16];
    assign w_funct  = i_instr[5:0];
    assign w_unused = ^i_instr[15:6];

    always_comb begin
        o_ctrl       = '0;
        o_ctrl.aluop = USELESS_OP;
        o_cp0_we     = 1'b0;
        o_cp0_re     = 1'b0;
        o_exc        = '0;
        w_invalid    = 1'b0;
        case (w_op)
            OP_SPECIAL: begin
                case (w_funct)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO,
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU: begin
                        o_ctrl.regwrite = 1'b1;
                        o_ctrl.regdst   = 1'b1;
                        o_ctrl.aluop    = R_TYPE_OP;
                    end
                    F_MTHI:                          o_ctrl.hilo_we = 2'b10;
                    F_MTLO:                          o_ctrl.hilo_we = 2'b01;
                    F_MULT, F_MULTU, F_DIV, F_DIVU:  o_ctrl.hilo_we = 2'b11;
                    F_JR:                            o_ctrl.jr = 1'b1;
                    F_JALR: begin
                        o_ctrl.regwrite = 1'b1;
                        o_ctrl.regdst   = 1'b1;
                        o_ctrl.jalr     = 1'b1;
                    end
                    F_SYSCALL: o_exc[EXC_SYSCALL] = 1'b1;
                    F_BREAK:   o_exc[EXC_BRK] = 1'b1;
                    default:   w_invalid = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ, RT_BGEZ: o_ctrl.branch = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        o_ctrl.regwrite = 1'b1;
                        o_ctrl.branch   = 1'b1;
                        o_ctrl.bal      = 1'b1;
                    end
                    default: w_invalid = 1'b1;
                endcase
            end
            OP_J: o_ctrl.jump = 1'b1;
            OP_JAL: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.jal      = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_ctrl.branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.aluop    = imm_aluop(w_op);
            end
            OP_COP0: begin
                case (w_rs)
                    RS_MFC0: begin
                        o_ctrl.regwrite = 1'b1;
                        o_ctrl.aluop    = MFC0_OP;
                        o_cp0_re        = 1'b1;
                    end
                    RS_MTC0: begin
                        o_ctrl.aluop = MTC0_OP;
                        o_cp0_we     = 1'b1;
                    end
                    RS_CO: begin
                        if (w_funct == F_ERET) o_exc[EXC_ERET] = 1'b1;
                        else                   w_invalid = 1'b1;
                    end
                    default: w_invalid = 1'b1;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.memen    = 1'b1;
                o_ctrl.aluop    = MEM_OP;
            end
            OP_SB, OP_SH, OP_SW: begin
                o_ctrl.alusrc = 1'b1;
                o_ctrl.memen  = 1'b1;
                o_ctrl.aluop  = MEM_OP;
            end
            default: w_invalid = 1'b1;
        endcase
        // Invalid encodings override anything a partial match may have set.
        if (w_invalid) begin
            o_ctrl             = '0;
            o_cp0_we           = 1'b0;
            o_cp0_re           = 1'b0;
            o_exc              = '0;
            o_exc[EXC_INVALID] = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes each fetched instruction on push and buffers the decoded
// entry in a DEPTH-entry FIFO between IF and the ID/EX register.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [PC_W-1:0]        out_pc,
    output logic [16:0]            out_ctrl,
    output logic                   out_cp0_we,
    output logic                   out_cp0_re,
    output logic [3:0]             out_exc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      r_instr_mem [DEPTH];
    logic [PC_W-1:0]  r_pc_mem    [DEPTH];
    ctrl_t            r_ctrl_mem  [DEPTH];
    logic             r_we_mem    [DEPTH];
    logic             r_re_mem    [DEPTH];
    logic [3:0]       r_exc_mem   [DEPTH];

    ctrl_t            w_ctrl;
    logic             w_cp0_we;
    logic             w_cp0_re;
    logic [3:0]       w_exc;
    logic             w_push;
    logic             w_pop;

    ctrl_decode u_ctrl_decode (
        .i_instr  (in_instr),
        .o_ctrl   (w_ctrl),
        .o_cp0_we (w_cp0_we),
        .o_cp0_re (w_cp0_re),
        .o_exc    (w_exc)
    );

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_ctrl_mem[r_wr_ptr]  <= w_ctrl;
            r_we_mem[r_wr_ptr]    <= w_cp0_we;
            r_re_mem[r_wr_ptr]    <= w_cp0_re;
            r_exc_mem[r_wr_ptr]   <= w_exc;
        end
    end

    assign out_instr  = out_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign out_pc     = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign out_ctrl   = out_valid ? r_ctrl_mem[r_rd_ptr]  : '0;
    assign out_cp0_we = out_valid ? r_we_mem[r_rd_ptr]    : 1'b0;
    assign out_cp0_re = out_valid ? r_re_mem[r_rd_ptr]    : 1'b0;
    assign out_exc    = out_valid ? r_exc_mem[r_rd_ptr]   : '0;

endmodule
